// File: rtl/fp_add_arbiter.sv
// Round-robin share of one pipelined FP adder among N_REQ requesters; optional FP_ADD_ZERO_BYPASS_EN skips the adder when an operand is +-0.
// Latency LAT+2 from grant to rsp_valid; one grant per cycle, no backpressure from adder or response side.
module fp_add_arbiter #(
   parameter int WIDTH     = 32,
   parameter int WIDTH_exp = 8,
   parameter int WIDTH_mat = 23,
   parameter int N_REQ     = 4,
   parameter int LAT       = 3
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]       OP_L,
   output logic [WIDTH-1:0]       OP_S,
   output logic                   op_valid,
   input  logic [WIDTH-1:0]       add_res,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   busy
);
   localparam int MAG_W = WIDTH_exp + WIDTH_mat;
   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             grant_vld;
   logic [IDX_W-1:0] grant_idx;
   int               cand;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic             swap, issue;
   logic [WIDTH-1:0] op_l_q, op_s_q, rsp_dat_q, rsp_dat_d;
   logic             op_vld_q;
   logic [N_REQ-1:0] rsp_vld_q;
   logic             tag_vld_q [LAT+1];
   logic [IDX_W-1:0] tag_idx_q [LAT+1];

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      if (!RST) begin
         for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr_q) + k) % N_REQ;
            if (!grant_vld && req_valid[cand]) begin
               grant_vld = 1'b1;
               grant_idx = IDX_W'(cand);
            end
         end
      end
      req_ready = '0;
      if (grant_vld) req_ready[grant_idx] = 1'b1;
      ptr_d = ptr_q;
      if (grant_vld) ptr_d = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
   end

   // Magnitude ignores the sign bit; a tie keeps A on the large side.
   assign a_sel = req_a[grant_idx*WIDTH +: WIDTH];
   assign b_sel = req_b[grant_idx*WIDTH +: WIDTH];
   assign swap  = a_sel[MAG_W-1:0] < b_sel[MAG_W-1:0];

`ifdef FP_ADD_ZERO_BYPASS_EN
   logic             a_zero, b_zero, byp;
   logic [WIDTH-1:0] byp_dat;
   logic             tag_byp_q [LAT+1];
   logic [WIDTH-1:0] tag_dat_q [LAT+1];

   assign a_zero    = (a_sel[MAG_W-1:0] == '0);
   assign b_zero    = (b_sel[MAG_W-1:0] == '0);
   assign byp       = a_zero | b_zero;
   assign byp_dat   = (a_zero && !b_zero) ? b_sel : a_sel;
   assign issue     = grant_vld && !byp;
   assign rsp_dat_d = tag_byp_q[LAT] ? tag_dat_q[LAT] : add_res;

   // Bypass payload is qualified by tag_vld_q, so it needs no reset.
   always_ff @(posedge CLK) begin
      tag_byp_q[0] <= byp;
      tag_dat_q[0] <= byp_dat;
      for (int k = 1; k <= LAT; k++) begin
         tag_byp_q[k] <= tag_byp_q[k-1];
         tag_dat_q[k] <= tag_dat_q[k-1];
      end
   end
`else
   assign issue     = grant_vld;
   assign rsp_dat_d = add_res;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q     <= '0;
         op_vld_q  <= 1'b0;
         op_l_q    <= '0;
         op_s_q    <= '0;
         rsp_vld_q <= '0;
         rsp_dat_q <= '0;
         for (int k = 0; k <= LAT; k++) begin
            tag_vld_q[k] <= 1'b0;
            tag_idx_q[k] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         op_vld_q <= issue;
         if (issue) begin
            op_l_q <= swap ? b_sel : a_sel;
            op_s_q <= swap ? a_sel : b_sel;
         end
         tag_vld_q[0] <= grant_vld;
         tag_idx_q[0] <= grant_idx;
         for (int k = 1; k <= LAT; k++) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            tag_idx_q[k] <= tag_idx_q[k-1];
         end
         rsp_vld_q <= '0;
         if (tag_vld_q[LAT]) begin
            rsp_vld_q[tag_idx_q[LAT]] <= 1'b1;
            rsp_dat_q                 <= rsp_dat_d;
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k <= LAT; k++) busy = busy | tag_vld_q[k];
   end

   assign OP_L      = op_l_q;
   assign OP_S      = op_s_q;
   assign op_valid  = op_vld_q;
   assign rsp_valid = rsp_vld_q;
   assign rsp_data  = rsp_dat_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: cycle-indexed reference model checked every cycle, plus directed literal checks.
module tb_fp_add_arbiter;
   localparam int W   = 32;
   localparam int N   = 4;
   localparam int LAT = 3;
   localparam int D   = 2048;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0, req_b = '0;
   logic [N-1:0]   req_ready, rsp_valid;
   logic [W-1:0]   OP_L, OP_S, rsp_data;
   logic [W-1:0]   add_res = '0;
   logic           op_valid, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   fp_add_arbiter #(.WIDTH(W), .WIDTH_exp(8), .WIDTH_mat(23), .N_REQ(N), .LAT(LAT)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .OP_L(OP_L), .OP_S(OP_S), .op_valid(op_valid),
      .add_res(add_res), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: expectations indexed by absolute cycle number.
   logic [N-1:0] m_rv   [D];
   logic         m_byp  [D];
   logic [W-1:0] m_bdat [D];
   logic [W-1:0] a_hist [D];
   logic         m_gnt  [D];
   int           mptr = 0;
   logic         m_opv = 1'b0;
   logic [W-1:0] m_opl = '0, m_ops = '0;

   initial begin
      for (int i = 0; i < D; i++) begin
         m_rv[i] = '0; m_byp[i] = 1'b0; m_bdat[i] = '0; a_hist[i] = '0; m_gnt[i] = 1'b0;
      end
   end

   always @(negedge CLK) begin
      int c, w;
      logic [N-1:0] er;
      logic [W-1:0] a, b;
      logic byp, mb;
      c = cyc;
      a_hist[c] = add_res;
      er = '0;
      w = -1;
      if (!RST) begin
         for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
      end
      if (w >= 0) er[w] = 1'b1;
      chk("req_ready", W'(req_ready), W'(er));
      chk("op_valid", W'(op_valid), W'(m_opv));
      if (m_opv) begin
         chk("OP_L", OP_L, m_opl);
         chk("OP_S", OP_S, m_ops);
      end
      chk("rsp_valid", W'(rsp_valid), W'(m_rv[c]));
      if (m_rv[c] != '0) chk("rsp_data", rsp_data, m_byp[c] ? m_bdat[c] : a_hist[c-1]);
      mb = 1'b0;
      for (int j = 1; j <= LAT + 1; j++)
         if (c - j >= 0 && m_gnt[c-j]) mb = 1'b1;
      chk("busy", W'(busy), W'(mb));

      m_opv = 1'b0;
      if (RST) begin
         mptr = 0;
         for (int j = 0; j <= c; j++) m_gnt[j] = 1'b0;
         for (int j = c + 1; j <= c + LAT + 2; j++) m_rv[j] = '0;
      end else if (w >= 0) begin
         a = req_a[w*W +: W];
         b = req_b[w*W +: W];
         byp = 1'b0;
`ifdef FP_ADD_ZERO_BYPASS_EN
         byp = (a[W-2:0] == 0) || (b[W-2:0] == 0);
`endif
         m_gnt[c] = 1'b1;
         if (!byp) begin
            m_opv = 1'b1;
            if (a[W-2:0] >= b[W-2:0]) begin m_opl = a; m_ops = b; end
            else begin m_opl = b; m_ops = a; end
         end
         m_rv[c+LAT+2]   = N'(1) << w;
         m_byp[c+LAT+2]  = byp;
         m_bdat[c+LAT+2] = (a[W-2:0] == 0 && b[W-2:0] != 0) ? b : a;
         mptr = (w + 1) % N;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      add_res = 32'h4100_0000 + W'(cyc);
   endtask

   task automatic drain();
      req_valid = '0;
      repeat (LAT + 4) tick();
   endtask

   task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[r*W +: W] = a;
      req_b[r*W +: W] = b;
   endtask

   logic [N-1:0] tbl4 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [N-1:0] tbl2 [2] = '{4'b1000, 4'b0010};

   initial begin
      set_op(0, 32'h4000_0000, 32'h3F00_0000);
      set_op(1, 32'h3F80_0000, 32'h4120_0000);
      set_op(2, 32'hC080_0000, 32'h4040_0000);
      set_op(3, 32'h3E80_0000, 32'hBF40_0000);
      req_valid = 4'hF;
      tick(); tick();
      @(negedge CLK);
      chk("rst_OP_L", OP_L, 32'h0);
      chk("rst_OP_S", OP_S, 32'h0);
      chk("rst_op_valid", W'(op_valid), 32'h0);
      chk("rst_rsp_valid", W'(rsp_valid), 32'h0);
      chk("rst_busy", W'(busy), 32'h0);
      chk("rst_req_ready", W'(req_ready), 32'h0);
      tick();
      RST = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         chk("rr4_grant", W'(req_ready), W'(tbl4[k%4]));
         if (k > 0) chk("rr4_op_valid", W'(op_valid), 32'h1);
         tick();
      end
      drain();

      // single op
      req_valid = 4'b0001;
      set_op(0, 32'h3F80_0000, 32'h4000_0000);
      @(negedge CLK);
      chk("single_grant", W'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      @(negedge CLK);
      chk("single_OP_L", OP_L, 32'h4000_0000);
      chk("single_OP_S", OP_S, 32'h3F80_0000);
      chk("single_op_valid", W'(op_valid), 32'h1);
      tick(); tick(); tick();
      add_res = 32'h4040_0000;
      tick();
      @(negedge CLK);
      chk("single_rsp_valid", W'(rsp_valid), 32'h1);
      chk("single_rsp_data", rsp_data, 32'h4040_0000);
      drain();

      // requesters 1 and 3 with ptr moved to 2
      req_valid = 4'b0010;
      @(negedge CLK);
      chk("r1_grant", W'(req_ready), 32'h2);
      tick();
      req_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("rr13_grant", W'(req_ready), W'(tbl2[k%2]));
         tick();
      end
      drain();

      // tie with opposite signs, then swap
      req_valid = 4'b0001;
      set_op(0, 32'hBF80_0000, 32'h3F80_0000);
      tick();
      set_op(0, 32'h3F00_0000, 32'hC040_0000);
      @(negedge CLK);
      chk("tie_OP_L", OP_L, 32'hBF80_0000);
      chk("tie_OP_S", OP_S, 32'h3F80_0000);
      tick();
      req_valid = '0;
      @(negedge CLK);
      chk("swap_OP_L", OP_L, 32'hC040_0000);
      chk("swap_OP_S", OP_S, 32'h3F00_0000);
      drain();

      // reset while two ops are in flight
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0100;
      tick();
      RST = 1'b1;
      req_valid = 4'b1001;
      @(negedge CLK);
      chk("midrst_ready", W'(req_ready), 32'h0);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_busy", W'(busy), 32'h0);
      chk("midrst_grant", W'(req_ready), 32'h1);
      chk("midrst_no_rsp", W'(rsp_valid & 4'b0110), 32'h0);
      tick();
      req_valid = '0;
      for (int k = 4; k <= 10; k++) begin
         @(negedge CLK);
         chk("midrst_no_rsp", W'(rsp_valid & 4'b0110), 32'h0);
         tick();
      end
      drain();

      // negative zero operand
      req_valid = 4'b0001;
      set_op(0, 32'h8000_0000, 32'h4040_0000);
      tick();
      req_valid = '0;
      @(negedge CLK);
`ifdef FP_ADD_ZERO_BYPASS_EN
      chk("zero_op_valid", W'(op_valid), 32'h0);
`else
      chk("zero_op_valid", W'(op_valid), 32'h1);
      chk("zero_OP_L", OP_L, 32'h4040_0000);
`endif
      tick(); tick(); tick();
      add_res = 32'h1234_5678;
      tick();
      @(negedge CLK);
      chk("zero_rsp_valid", W'(rsp_valid), 32'h1);
`ifdef FP_ADD_ZERO_BYPASS_EN
      chk("zero_rsp_data", rsp_data, 32'h4040_0000);
`else
      chk("zero_rsp_data", rsp_data, 32'h1234_5678);
`endif
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin scheduler that shares one fully pipelined floating-point adder (align → mantissa add → normalize/round) among `N_REQ` IIR-filter requesters. It accepts operand pairs over a valid/ready handshake and orders each pair by magnitude so the align stage always receives the larger operand on `OP_L`. It tracks the requester of every in-flight operation through a tag pipeline matched to the adder latency, and routes each sum back to the requester that issued it.

## Interface
- `WIDTH`, 32, total bits of an IEEE-754 operand
- `WIDTH_exp`, 8, exponent bits
- `WIDTH_mat`, 23, mantissa bits
- `N_REQ`, 4, number of requesters (2..8)
- `LAT`, 3, adder latency: cycles from `op_valid` high to `add_res` valid (≥1)

Ports:
- `CLK` in 1: single clock, all logic on rising edge
- `RST` in 1: reset, synchronous and active-high
- `req_valid` in `N_REQ`: per-requester operation request
- `req_a` in `N_REQ*WIDTH`: operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b` in `N_REQ*WIDTH`: operand B, same packing
- `req_ready` out `N_REQ`: one-hot grant, combinational from `req_valid` and the pointer
- `OP_L` out `WIDTH`: larger-magnitude operand to the adder, registered
- `OP_S` out `WIDTH`: smaller-magnitude operand to the adder, registered
- `op_valid` out 1: `OP_L`/`OP_S` valid this cycle
- `add_res` in `WIDTH`: adder sum, sampled `LAT` cycles after `op_valid`
- `rsp_valid` out `N_REQ`: one-hot result strobe, one cycle
- `rsp_data` out `WIDTH`: result for the strobed requester
- `busy` out 1: any operation in flight (OR of tag-pipeline valids)

## Operation
- Transfer occurs when `req_valid[i] && req_ready[i]`. At most one grant per cycle; the adder accepts one operation per cycle and has no backpressure.
- Arbitration: round-robin from pointer `ptr`. The lowest index ≥ `ptr` with `req_valid` set wins, wrapping modulo `N_REQ`. After a grant to i, `ptr` becomes (i+1) mod `N_REQ`. With no grant, `ptr` holds.
- Magnitude ordering compares `{exp, mantissa}` (bits [WIDTH-2:0]) unsigned and ignores sign. If |A| ≥ |B|, then `OP_L`=A and `OP_S`=B; otherwise the two are swapped. On a tie, A goes to `OP_L`.
- No special handling of NaN, Inf or denormals; they are compared by raw bits.
- Tag pipeline: `LAT`+1 stages, each stage holding {valid, requester index, bypass flag, bypass data}. It shifts every cycle. The tail stage drives the registered response: `rsp_valid[idx]`=1 and `rsp_data`=`add_res` (or the bypass data).
- Responses return in issue order. Requesters must accept `rsp_valid` unconditionally.
- A requester may keep `req_valid` high for back-to-back operations. A new grant in the same cycle a response returns is legal.
- Reset values: `OP_L`=0, `OP_S`=0, `op_valid`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `ptr`=0, all tag valids 0.
- A reset asserted mid-operation discards every in-flight tag. No `rsp_valid` follows for operations issued before the reset, even though `add_res` may still change.

## Timing
- Handshake in cycle t: `OP_L`/`OP_S`/`op_valid` are valid in cycle t+1.
- `add_res` is sampled in cycle t+1+`LAT`.
- `rsp_valid`/`rsp_data` are valid in cycle t+2+`LAT`. Total latency is `LAT`+2 cycles.
- Throughput is one operation per cycle, with no bubbles under continuous requests.
- `op_valid` is low in every cycle that follows a cycle with no grant.
- `req_ready` is combinational. It is 0 for all requesters while `RST`=1.

## Configuration
- `FP_ADD_ZERO_BYPASS_EN` defined: if either operand is ±0 (bits [WIDTH-2:0]==0), the adder is not issued and `op_valid` stays 0 that cycle.
  - The other operand (A if both are zero) is carried in the tag pipeline as bypass data.
  - It returns on `rsp_data` with the same `LAT`+2 latency, preserving ordering.
- Macro undefined: every operation is issued to the adder. The bypass fields are not instantiated.

## Test plan
- Single op, `LAT`=3: req0 A=0x3F800000, B=0x40000000 at t. Required: `OP_L`=0x40000000, `OP_S`=0x3F800000, `op_valid`=1 at t+1. Bench drives `add_res`=0x40400000 at t+4. Required: `rsp_valid`=4'b0001, `rsp_data`=0x40400000 at t+5.
- All four requesters hold `req_valid` from reset. Required: grants 0,1,2,3,0,… in consecutive cycles, `op_valid` continuously 1, `rsp_valid` strobes in the same order with no gaps.
- Only requesters 1 and 3 request, with `ptr`=2. Required: grants alternate 3,1,3,1.
- Tie and sign: A=0xBF800000, B=0x3F800000. Required: `OP_L`=0xBF800000, `OP_S`=0x3F800000. Swap case A=0x3F000000, B=0xC0400000. Required: `OP_L`=0xC0400000.
- Two ops issued at t and t+1, `RST` high at t+2 for one cycle. Required: no `rsp_valid` through t+10, `busy`=0 and `ptr`=0 after reset, new request at t+3 granted to the lowest valid index.
- With `FP_ADD_ZERO_BYPASS_EN`, A=0x80000000, B=0x40400000. Required: `op_valid`=0, `rsp_data`=0x40400000 at t+5. Without the macro: `op_valid`=1 with `OP_L`=0x40400000.
